// File: rtl/regfile_bypass_unit.sv
// Writeback-to-decode forwarding unit.
// WB writes travel through a DEPTH-stage commit pipeline before reaching the
// register file. Each read port is bypassed from the youngest matching write:
// the live WB write first, then s[0] through s[DEPTH-1].
module regfile_bypass_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_waddr,
  input  logic [DATA_W-1:0]        wb_wdata,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_rdata,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_fwd_hit,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [CNT_W-1:0]         pend_cnt
);

  logic [DEPTH-1:0]             r_v;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [CNT_W-1:0]             r_pend;

  logic                         w_wb_vld;
  logic [CNT_W-1:0]             w_pend_nxt;

  // Writes to register 0 enter the pipeline as invalid bubbles
  assign w_wb_vld = wb_we & (wb_waddr != '0);

  // Occupancy after the next shift: the new s[0] plus s[0..DEPTH-2] moving down
  always_comb begin
    w_pend_nxt = CNT_W'(w_wb_vld);
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      w_pend_nxt = w_pend_nxt + CNT_W'(r_v[i]);
    end
  end

  // Commit pipeline: always advances, reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_pend <= '0;
    end else begin
      r_v[0]    <= w_wb_vld;
      r_addr[0] <= wb_waddr;
      r_data[0] <= wb_wdata;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_v[i]    <= r_v[i-1];
        r_addr[i] <= r_addr[i-1];
        r_data[i] <= r_data[i-1];
      end
      r_pend <= w_pend_nxt;
    end
  end

  // Oldest stage drives the register-file write port
  assign rf_we    = r_v[DEPTH-1];
  assign rf_waddr = r_addr[DEPTH-1];
  assign rf_wdata = r_data[DEPTH-1];
  assign pend_cnt = r_pend;

  // Per-port bypass: scan oldest to youngest so the youngest match is applied last
  always_comb begin
    logic [ADDR_W-1:0] w_a;
    int unsigned       w_j;
    rd_data    = rf_rdata;
    rd_fwd_hit = '0;
    w_a        = '0;
    w_j        = 0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      w_a = rd_addr[p*ADDR_W +: ADDR_W];
      if (w_a != '0) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          w_j = DEPTH - 1 - i;
          if (r_v[w_j] && (r_addr[w_j] == w_a)) begin
            rd_data[p*DATA_W +: DATA_W] = r_data[w_j];
            rd_fwd_hit[p]               = 1'b1;
          end
        end
        if (w_wb_vld && (wb_waddr == w_a)) begin
          rd_data[p*DATA_W +: DATA_W] = wb_wdata;
          rd_fwd_hit[p]               = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_bypass_unit.sv
// Self-checking bench for regfile_bypass_unit (DEPTH=2, NUM_RD=3).
// Valid WB writes are pushed to a scoreboard with the cycle they must commit;
// a negedge monitor pops them against rf_we/rf_waddr/rf_wdata and checks pend_cnt.
module tb_regfile_bypass_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 3;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     wb_we = 1'b0;
  logic [ADDR_W-1:0]        wb_waddr = '0;
  logic [DATA_W-1:0]        wb_wdata = '0;
  logic [ADDR_W-1:0]        ra  [NUM_RD];
  logic [DATA_W-1:0]        rfd [NUM_RD];
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rf_rdata;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_fwd_hit;
  logic                     rf_we;
  logic [ADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]        rf_wdata;
  logic [CNT_W-1:0]         pend_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;
  ent_t q[$];

  assign rd_addr  = {ra[2], ra[1], ra[0]};
  assign rf_rdata = {rfd[2], rfd[1], rfd[0]};

  regfile_bypass_unit #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .rd_addr   (rd_addr),
    .rf_rdata  (rf_rdata),
    .rd_data   (rd_data),
    .rd_fwd_hit(rd_fwd_hit),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected {hit, data} for one port from the scoreboard contents and the live WB inputs
  function automatic logic [DATA_W:0] model_rd(input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] rf);
    logic [DATA_W:0] r;
    r = {1'b0, rf};
    if (a != '0) begin
      foreach (q[i]) begin
        if (q[i].due <= cyc + DEPTH - 1 && q[i].addr == a) r = {1'b1, q[i].data};
      end
      if (wb_we && wb_waddr == a) r = {1'b1, wb_wdata};
    end
    return r;
  endfunction

  function automatic int model_pend();
    int n;
    n = 0;
    foreach (q[i]) if (q[i].due <= cyc + DEPTH - 1) n++;
    return n;
  endfunction

  // Record the driven write, check all read ports, then advance one clock
  task automatic tick();
    logic [DATA_W:0] e;
    if (rst_n && wb_we && wb_waddr != '0) q.push_back('{cyc + DEPTH, wb_waddr, wb_wdata});
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      e = model_rd(ra[p], rfd[p]);
      check("rd_data", 64'(rd_data[p*DATA_W +: DATA_W]), 64'(e[DATA_W-1:0]));
      check("rd_hit", 64'(rd_fwd_hit[p]), 64'(e[DATA_W]));
    end
    @(posedge clk);
    #1;
  endtask

  // Commit monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rf_we", 64'(rf_we), 64'(0));
      check("rst_pend", 64'(pend_cnt), 64'(0));
    end else begin
      check("pend_cnt", 64'(pend_cnt), 64'(model_pend()));
      if (q.size() > 0 && q[0].due == cyc) begin
        check("rf_we", 64'(rf_we), 64'(1));
        check("rf_waddr", 64'(rf_waddr), 64'(q[0].addr));
        check("rf_wdata", 64'(rf_wdata), 64'(q[0].data));
        void'(q.pop_front());
      end else begin
        check("rf_we_idle", 64'(rf_we), 64'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < NUM_RD; p++) begin
      ra[p]  = '0;
      rfd[p] = 32'h0BAD_0000 + 32'(p);
    end

    // Reset held with a live WB write: nothing tracked, live write still forwards
    rst_n = 1'b0; wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1234_5678; ra[0] = 5'd5;
    @(posedge clk); #1;
    repeat (3) begin
      #1;
      check("rst_fwd_data", 64'(rd_data[31:0]), 64'h1234_5678);
      check("rst_fwd_hit", 64'(rd_fwd_hit[0]), 64'(1));
      check("rst_pend_now", 64'(pend_cnt), 64'(0));
      tick();
    end
    rst_n = 1'b1; wb_we = 1'b0;
    tick();

    // Latency: r3 written at cycle 0 commits after the second edge
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hAAAA_5555; ra[0] = 5'd3; rfd[0] = 32'h0;
    #1; check("lat_c0_data", 64'(rd_data[31:0]), 64'hAAAA_5555);
    check("lat_c0_hit", 64'(rd_fwd_hit[0]), 64'(1));
    tick();
    wb_we = 1'b0;
    #1; check("lat_c1_data", 64'(rd_data[31:0]), 64'hAAAA_5555);
    check("lat_c1_hit", 64'(rd_fwd_hit[0]), 64'(1));
    check("lat_c1_rf_we", 64'(rf_we), 64'(0));
    tick();
    #1; check("lat_c2_data", 64'(rd_data[31:0]), 64'hAAAA_5555);
    check("lat_c2_hit", 64'(rd_fwd_hit[0]), 64'(1));
    check("lat_c2_rf_we", 64'(rf_we), 64'(1));
    check("lat_c2_rf_waddr", 64'(rf_waddr), 64'(3));
    tick();
    tick();

    // Priority: youngest of three writes to r7 wins, commits land in order
    ra[0] = 5'd7;
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h11; tick();
    wb_wdata = 32'h22; tick();
    wb_wdata = 32'h33;
    #1; check("prio_live", 64'(rd_data[31:0]), 64'h33);
    wb_we = 1'b0;
    #1; check("prio_s0", 64'(rd_data[31:0]), 64'h22);
    tick();
    tick();
    tick();

    // Register 0: bubble only, never forwarded or committed
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hDEAD; ra[0] = 5'd0; rfd[0] = 32'h0;
    #1; check("r0_data", 64'(rd_data[31:0]), 64'h0);
    check("r0_hit", 64'(rd_fwd_hit[0]), 64'(0));
    tick();
    wb_we = 1'b0;
    tick();
    tick();

    // Multi-port: r4 in s[1], r9 live at WB
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h4444_4444; tick();
    wb_we = 1'b0; tick();
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h9999_9999;
    ra[0] = 5'd4; ra[1] = 5'd9; ra[2] = 5'd4;
    #1; check("mp_p0", 64'(rd_data[31:0]), 64'h4444_4444);
    check("mp_p1", 64'(rd_data[63:32]), 64'h9999_9999);
    check("mp_p2", 64'(rd_data[95:64]), 64'h4444_4444);
    check("mp_hit", 64'(rd_fwd_hit), 64'(3'b111));
    tick();
    wb_we = 1'b0; tick(); tick();

    // Reset mid-flight: r1 in s[0], r2 live; neither may ever commit
    ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd0;
    wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'h0101_0101; tick();
    wb_waddr = 5'd2; wb_wdata = 32'h0202_0202;
    #1; check("mf_pend_before", 64'(pend_cnt), 64'(1));
    rst_n = 1'b0; q.delete();
    #1; check("mf_pend_now", 64'(pend_cnt), 64'(0));
    check("mf_rf_we_now", 64'(rf_we), 64'(0));
    wb_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (DEPTH + 2) tick();

    // Random traffic over a small register set to exercise duplicates and port aliasing
    for (int n = 0; n < 120; n++) begin
      wb_we    = ($urandom_range(0, 3) != 0);
      wb_waddr = 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      for (int p = 0; p < NUM_RD; p++) begin
        ra[p]  = 5'($urandom_range(0, 7));
        rfd[p] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) ra[1] = ra[0];
      tick();
    end

    wb_we = 1'b0;
    repeat (DEPTH + 1) tick();
    check("drain", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
